// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    typedef struct packed {
        logic  carry;
        bcd2_t val;
    } bcd_inc_t;

    // Mod-60 BCD increment; carry is set on the 59 -> 00 roll.
    function automatic bcd_inc_t bcd60_inc(input bcd2_t v);
        bcd_inc_t r;
        r.carry = 1'b0;
        r.val   = v;
        if (v.ones == DIGIT_MAX) begin
            r.val.ones = 4'd0;
            if (v.tens == TENS_MAX) begin
                r.val.tens = 4'd0;
                r.carry    = 1'b1;
            end else begin
                r.val.tens = v.tens + 4'd1;
            end
        end else begin
            r.val.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_tick_sync.sv
// Synchronizer plus rising-edge detector: turns a slow square wave into a
// registered single-cycle tick in the src_clk domain.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic src_clk,
    input  logic reset,
    input  logic din,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q resets low so an input already high at release gives one tick.
    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core with run/pause/clear and optional manual adjust.
// Adjust mode is built only when STOPWATCH_ADJUST_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       src_clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adj_active,
    output logic       wrap
);

    state_t   state_q, state_d;
    bcd2_t    min_q, min_d, sec_q, sec_d;
    bcd_inc_t min_inc, sec_inc;
    logic     wrap_d;
    logic     tick_1hz;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
        .src_clk (src_clk),
        .reset   (reset),
        .din     (clk_1hz),
        .tick    (tick_1hz)
    );

`ifdef STOPWATCH_ADJUST_EN
    logic tick_2hz;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
        .src_clk (src_clk),
        .reset   (reset),
        .din     (clk_2hz),
        .tick    (tick_2hz)
    );
`else
    logic unused_adj;
    assign unused_adj = ^{clk_2hz, sw_adj, sw_sel};
`endif

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        wrap_d  = 1'b0;
        sec_inc = bcd60_inc(sec_q);
        min_inc = bcd60_inc(min_q);

        if (btn_clear) begin
            min_d   = '0;
            sec_d   = '0;
            state_d = (state_q == ADJUST) ? ADJUST : IDLE;
        end
`ifdef STOPWATCH_ADJUST_EN
        else if (state_q != ADJUST && sw_adj) begin
            state_d = ADJUST;
        end else if (state_q == ADJUST && !sw_adj) begin
            state_d = PAUSE;
        end else if (state_q == ADJUST) begin
            // Single-field increment: no carry between fields, no wrap pulse.
            if (tick_2hz) begin
                if (sw_sel) min_d = min_inc.val;
                else        sec_d = sec_inc.val;
            end
        end
`endif
        else begin
            case (state_q)
                IDLE:  if (btn_pause) state_d = RUN;
                RUN: begin
                    // A tick coinciding with pause is still counted.
                    if (tick_1hz) begin
                        sec_d = sec_inc.val;
                        if (sec_inc.carry) begin
                            min_d  = min_inc.val;
                            wrap_d = min_inc.carry;
                        end
                    end
                    if (btn_pause) state_d = PAUSE;
                end
                PAUSE: if (btn_pause) state_d = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            running <= (state_d == RUN);
            wrap    <= wrap_d;
        end
    end

`ifdef STOPWATCH_ADJUST_EN
    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) adj_active <= 1'b0;
        else        adj_active <= (state_d == ADJUST);
    end
`else
    assign adj_active = 1'b0;
`endif

    assign min_tens = min_q.tens;
    assign min_ones = min_q.ones;
    assign sec_tens = sec_q.tens;
    assign sec_ones = sec_q.ones;

endmodule
